// File: rtl/pd_search_pkg.sv
// Shared register map, field positions and tap record for the codeword-search peripheral.
package pd_search_pkg;

    localparam logic [5:0] REG_DATA_LO = 6'd0;
    localparam logic [5:0] REG_DATA_HI = 6'd4;
    localparam logic [5:0] REG_PTR     = 6'd8;
    localparam logic [5:0] REG_CR      = 6'd16;
    localparam logic [5:0] REG_ST      = 6'd24;
    localparam logic [5:0] REG_TAP     = 6'd32;
    localparam logic [5:0] REG_STEPS   = 6'd40;

    localparam int CR_RUN    = 16;
    localparam int CR_INT_EN = 17;

    localparam int ST_RUNNING = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_MATCHED = 2;
    localparam int ST_TIMEOUT = 3;

    localparam int TAP_EN       = 31;
    localparam int TAP_IDX_LSB  = 16;
    localparam int TAP_WORD_LSB = 8;
    localparam int TAP_POS_LSB  = 0;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic       en;
        logic [3:0] word;
        logic [5:0] pos;
    } tap_t;

    localparam int TAP_W = $bits(tap_t);

    function automatic tap_t decode_tap(input logic [31:0] d);
        tap_t t;
        t.en   = d[TAP_EN];
        t.word = d[TAP_WORD_LSB +: 4];
        t.pos  = d[TAP_POS_LSB +: 6];
        return t;
    endfunction

endpackage

// File: rtl/pd_search_tap_match.sv
// Combinational multi-tap matcher: AND of the selected codeword bits over all enabled taps.
module pd_search_tap_match
    import pd_search_pkg::*;
#(
    parameter int WRDS  = 4,
    parameter int WW    = 64,
    parameter int NTAPS = 8
) (
    input  logic [WRDS*WW-1:0]     words,
    input  logic [NTAPS*TAP_W-1:0] taps,
    output logic                   matched
);

    logic [63:0] rows [16];
    tap_t        tap;
    logic        any_en;
    logic        all_hit;

    // Zero-filled 16x64 view makes out-of-range word or bit indices read as 0.
    always_comb begin
        for (int i = 0; i < 16; i++) rows[i] = '0;
        for (int i = 0; i < WRDS; i++) rows[i] = 64'(words[i*WW +: WW]);
        any_en  = 1'b0;
        all_hit = 1'b1;
        tap     = '0;
        for (int t = 0; t < NTAPS; t++) begin
            tap = tap_t'(taps[t*TAP_W +: TAP_W]);
            if (tap.en) begin
                any_en  = 1'b1;
                all_hit = all_hit & rows[tap.word][tap.pos];
            end
        end
        matched = any_en & all_hit;
    end

endmodule

// File: rtl/pd_codeword_search.sv
// Memory-mapped codeword-search peripheral: folds codewords each cycle until a tap match or step limit.
module pd_codeword_search
    import pd_search_pkg::*;
#(
    parameter int WRDS  = 4,
    parameter int WW    = 64,
    parameter int SHIFT = 4,
    parameter int NTAPS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  addr,
    input  logic        hwen,
    input  logic        hren,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt
);

    logic [WW-1:0]          words      [WRDS];
    logic [WW-1:0]          words_next [WRDS];
    logic [WRDS*WW-1:0]     words_flat;
    logic [NTAPS*TAP_W-1:0] taps;
    logic [3:0]             ptr;
    logic [15:0]            limit;
    logic [15:0]            steps;
    logic                   running;
    logic                   int_en;
    logic                   done;
    logic                   timeout;
    logic                   matched;
    logic                   cr_wr, st_wr, ptr_wr, tap_wr, data_wr;
    logic                   at_limit, fold;
    logic [63:0]            wide;
    logic [63:0]            rd_word;
    logic                   unused_hren;

    assign unused_hren = hren;

    assign cr_wr    = hwen && (addr == REG_CR);
    assign st_wr    = hwen && (addr == REG_ST);
    assign ptr_wr   = hwen && (addr == REG_PTR);
    assign tap_wr   = hwen && (addr == REG_TAP);
    assign data_wr  = hwen && !running &&
                      ((addr == REG_DATA_LO) || ((addr == REG_DATA_HI) && (WW == 64)));
    assign at_limit = (limit != 16'd0) && (steps == limit);
    // A CR write in the same cycle takes precedence over both stopping and folding.
    assign fold     = running && !cr_wr && !matched && !at_limit;

    for (genvar g = 0; g < WRDS; g++) begin : g_flat
        assign words_flat[g*WW +: WW] = words[g];
    end

    pd_search_tap_match #(
        .WRDS  (WRDS),
        .WW    (WW),
        .NTAPS (NTAPS)
    ) u_match (
        .words   (words_flat),
        .taps    (taps),
        .matched (matched)
    );

    always_comb begin
        wide = '0;
        for (int i = 0; i < WRDS; i++) words_next[i] = words[i];
        if (fold) begin
            for (int i = 0; i < WRDS - 1; i++) words_next[i] = words[i] | (words[i+1] >> SHIFT);
            words_next[WRDS-1] = '1;
        end else if (data_wr) begin
            for (int i = 0; i < WRDS; i++) begin
                if (ptr == 4'(i)) begin
                    wide = 64'(words[i]);
                    if (addr == REG_DATA_LO) wide[31:0] = wdata;
                    else                     wide[63:32] = wdata;
                    words_next[i] = wide[WW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WRDS; i++) words[i] <= '0;
        end else begin
            for (int i = 0; i < WRDS; i++) words[i] <= words_next[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps <= '0;
        end else if (tap_wr) begin
            for (int t = 0; t < NTAPS; t++) begin
                if (wdata[TAP_IDX_LSB +: 4] == 4'(t)) taps[t*TAP_W +: TAP_W] <= decode_tap(wdata);
            end
        end
    end

    // The stop branches come after the W1C clear so a freshly raised done survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            limit   <= '0;
            steps   <= '0;
            running <= 1'b0;
            int_en  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (ptr_wr) ptr <= wdata[3:0];
            if (st_wr && wdata[ST_DONE]) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end
            if (cr_wr) begin
                limit   <= wdata[15:0];
                int_en  <= wdata[CR_INT_EN];
                running <= wdata[CR_RUN];
                if (wdata[CR_RUN]) begin
                    steps   <= '0;
                    done    <= 1'b0;
                    timeout <= 1'b0;
                end
            end else if (running) begin
                if (matched) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else if (at_limit) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else if (steps != 16'hFFFF) begin
                    steps <= steps + 16'd1;
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WRDS; i++) begin
            if (ptr == 4'(i)) rd_word = 64'(words[i]);
        end
        rdata = BAD_ADDR_DATA;
        case (addr)
            REG_DATA_LO: rdata = rd_word[31:0];
            REG_DATA_HI: rdata = rd_word[63:32];
            REG_PTR:     rdata = {28'd0, ptr};
            REG_CR: begin
                rdata            = '0;
                rdata[15:0]      = limit;
                rdata[CR_RUN]    = running;
                rdata[CR_INT_EN] = int_en;
            end
            REG_ST: begin
                rdata             = '0;
                rdata[ST_RUNNING] = running;
                rdata[ST_DONE]    = done;
                rdata[ST_MATCHED] = matched;
                rdata[ST_TIMEOUT] = timeout;
            end
            REG_TAP:     rdata = '0;
            REG_STEPS:   rdata = {16'd0, steps};
            default:     rdata = BAD_ADDR_DATA;
        endcase
    end

    assign interrupt = int_en & done;

endmodule

// File: tb/tb_pd_codeword_search.sv
// Directed scoreboard bench for pd_codeword_search (64-bit instance plus a 32-bit instance on the same bus).
module tb_pd_codeword_search;

    localparam logic [5:0] A_LO    = 6'd0;
    localparam logic [5:0] A_HI    = 6'd4;
    localparam logic [5:0] A_PTR   = 6'd8;
    localparam logic [5:0] A_CR    = 6'd16;
    localparam logic [5:0] A_ST    = 6'd24;
    localparam logic [5:0] A_TAP   = 6'd32;
    localparam logic [5:0] A_STEPS = 6'd40;
    localparam logic [5:0] A_BAD   = 6'd48;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic        hwen;
    logic        hren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata32;
    logic        interrupt;
    logic        interrupt32;

    sb_item_t    sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mw [4];

    always #5 clk = ~clk;

    pd_codeword_search #(.WRDS(4), .WW(64), .SHIFT(4), .NTAPS(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .hwen      (hwen),
        .hren      (hren),
        .wdata     (wdata),
        .rdata     (rdata),
        .interrupt (interrupt)
    );

    pd_codeword_search #(.WRDS(4), .WW(32), .SHIFT(4), .NTAPS(8)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .hwen      (hwen),
        .hren      (hren),
        .wdata     (wdata),
        .rdata     (rdata32),
        .interrupt (interrupt32)
    );

    task automatic apply_stimulus(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        hwen  = 1'b1;
        @(posedge clk);
        #1;
        hwen  = 1'b0;
    endtask

    task automatic push_expect(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic check_output(input logic [31:0] obs);
        sb_item_t it;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("[TB] FAIL scoreboard_empty observed=%h", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        push_expect(tag, exp);
        hren = 1'b1;
        addr = a;
        #1;
        check_output(rdata);
        hren = 1'b0;
    endtask

    task automatic read_check32(input string tag, input logic [5:0] a, input logic [31:0] exp);
        push_expect(tag, exp);
        addr = a;
        #1;
        check_output(rdata32);
    endtask

    task automatic int_check(input string tag, input logic exp);
        push_expect(tag, {31'd0, exp});
        check_output({31'd0, interrupt});
    endtask

    task automatic model_fold(input int n);
        logic [63:0] nw [4];
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 3; i++) nw[i] = mw[i] | (mw[i+1] >> 4);
            nw[3] = '1;
            for (int i = 0; i < 4; i++) mw[i] = nw[i];
        end
    endtask

    initial begin
        reset = 1'b1;
        hwen  = 1'b0;
        hren  = 1'b0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 4; i++) mw[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state; no enabled taps must not count as a match.
        @(negedge clk);
        read_check("reset_st", A_ST, 32'd0);
        read_check("reset_steps", A_STEPS, 32'd0);
        read_check("bad_offset", A_BAD, 32'hDEADBEEF);
        int_check("reset_int", 1'b0);
        @(negedge clk);
        read_check("reset_data_lo", A_LO, 32'd0);
        read_check("reset_cr", A_CR, 32'd0);

        // Match run: word3 preloaded to ones, tap0 on word2 bit59.
        apply_stimulus(A_PTR, 32'd3);
        apply_stimulus(A_LO, 32'hFFFF_FFFF);
        apply_stimulus(A_HI, 32'hFFFF_FFFF);
        mw[3] = '1;
        apply_stimulus(A_TAP, 32'h8000_023B);
        apply_stimulus(A_CR, 32'h0003_0000);
        @(negedge clk);
        read_check("match_running", A_ST, 32'h1);
        @(negedge clk);
        read_check("match_pre_stop", A_ST, 32'h5);
        int_check("match_int_low", 1'b0);
        read_check32("ww32_tap_bit_oob", A_ST, 32'h1);
        @(negedge clk);
        read_check("match_st", A_ST, 32'h6);
        read_check("match_steps", A_STEPS, 32'd1);
        int_check("match_int", 1'b1);
        model_fold(1);
        apply_stimulus(A_PTR, 32'd2);
        read_check("match_w2_hi", A_HI, mw[2][63:32]);
        read_check("match_w2_lo", A_LO, mw[2][31:0]);

        // Timeout run: unreachable tap, limit 5.
        apply_stimulus(A_TAP, 32'h8000_003F);
        apply_stimulus(A_CR, 32'h0003_0005);
        repeat (5) @(posedge clk);
        @(negedge clk);
        read_check("timeout_running", A_ST, 32'h1);
        @(negedge clk);
        read_check("timeout_st", A_ST, 32'hA);
        read_check("timeout_steps", A_STEPS, 32'd5);
        int_check("timeout_int", 1'b1);
        model_fold(5);
        apply_stimulus(A_PTR, 32'd0);
        read_check("timeout_w0_lo", A_LO, mw[0][31:0]);
        read_check("timeout_w0_hi", A_HI, mw[0][63:32]);
        apply_stimulus(A_PTR, 32'd1);
        read_check("timeout_w1_hi", A_HI, mw[1][63:32]);

        // Write-1-to-clear of done/timeout.
        apply_stimulus(A_ST, 32'h2);
        read_check("clear_st", A_ST, 32'd0);
        int_check("clear_int", 1'b0);
        read_check("clear_steps_kept", A_STEPS, 32'd5);

        // Abort after three folds; words must then stay frozen.
        apply_stimulus(A_CR, 32'h0003_0000);
        repeat (3) @(posedge clk);
        apply_stimulus(A_CR, 32'h0002_0000);
        @(negedge clk);
        read_check("abort_st", A_ST, 32'd0);
        read_check("abort_steps", A_STEPS, 32'd3);
        int_check("abort_int", 1'b0);
        model_fold(3);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(A_PTR, 32'(i));
            read_check($sformatf("abort_w%0d_lo", i), A_LO, mw[i][31:0]);
            read_check($sformatf("abort_w%0d_hi", i), A_HI, mw[i][63:32]);
        end

        // DATA write while running is dropped.
        apply_stimulus(A_PTR, 32'd1);
        apply_stimulus(A_CR, 32'h0003_0000);
        apply_stimulus(A_LO, 32'h1234_5678);
        apply_stimulus(A_CR, 32'h0002_0000);
        model_fold(1);
        read_check("run_write_ignored", A_LO, mw[1][31:0]);
        read_check("run_write_steps", A_STEPS, 32'd1);

        // Pointer beyond the word count.
        apply_stimulus(A_PTR, 32'd7);
        apply_stimulus(A_LO, 32'hCAFE_F00D);
        read_check("ptr7_lo_read", A_LO, 32'd0);
        read_check("ptr7_hi_read", A_HI, 32'd0);
        apply_stimulus(A_PTR, 32'd3);
        read_check("ptr7_no_alias", A_LO, mw[3][31:0]);

        // 32-bit instance ignores DATA_HI.
        apply_stimulus(A_PTR, 32'd0);
        apply_stimulus(A_LO, 32'hA5A5_5A5A);
        apply_stimulus(A_HI, 32'h1234_5678);
        read_check32("ww32_lo", A_LO, 32'hA5A5_5A5A);
        read_check32("ww32_hi_zero", A_HI, 32'd0);
        read_check("ww64_hi", A_HI, 32'h1234_5678);
        read_check("tap_reads_zero", A_TAP, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
